svn_scan_drv: RTL and testbench
===============================

Name: svn_scan_drv

Overview:
Parametrised multiplexed seven-segment display driver for the board's common-anode multi-digit display. Scans NUM_DIGITS digits with a refresh divider and an anti-ghost blanking gap, and decodes 4-bit codes to active-low {CA..CG,DP}. Optional hex glyphs and leading-zero suppression are supported. New values are double-buffered and applied only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
REFRESH_DIV, 100000, clk cycles per digit slot (legal >=2)
BLANK_CYC, 1000, cycles at start of each slot with all anodes off (legal 0..REFRESH_DIV-1)
HEX_EN, 1, 1: codes A-F show hex glyphs; 0: codes A-F blank

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; capture data_in/dp_in/lz_en into pending buffer
data_in  in  4*NUM_DIGITS  digit codes; digit i = data_in[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
lz_en  in  1  leading-zero suppression enable
CA,CB,CC,CD,CE,CF,CG,DP  out  1 each  segment cathodes, active-low, registered
AN  out  NUM_DIGITS  digit anodes, active-low one-hot, registered
frame_done  out  1  one-cycle pulse when scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Reset (async assert, sync release): cnt=0, idx=0, pending/active buffers=0, pend_flag=0. AN all 1, all segments and DP 1 (dark), frame_done 0.
- Slot counter cnt runs 0..REFRESH_DIV-1. At the terminal count, idx advances and wraps NUM_DIGITS-1 -> 0.
- wrap = terminal count AND idx==NUM_DIGITS-1. frame_done is registered; it is 1 in the cycle after wrap.
- Outputs are registered from (cnt, idx, active buffer), so latency is 1 cycle.
  - If cnt < BLANK_CYC: AN all 1, segments all 1.
  - Otherwise: AN[idx]=0 and all other AN bits 1; segments = glyph(active digit idx).
- Glyph table, active-low CA..CG:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. If HEX_EN=0, A-F = 1111111.
- DP = ~active_dp[idx]. DP is unaffected by zero suppression.
- Leading-zero suppression: if active lz_en=1, digits from NUM_DIGITS-1 downward whose code is 0 are blanked (CA..CG=1111111) up to the first nonzero digit. Digit 0 is never suppressed. Example: all-zero value shows "0".
- Double buffering:
  - load=1 writes pending buffer and sets pend_flag. Back-to-back loads: last wins.
  - On wrap with pend_flag=1: pending buffer copies to active and pend_flag clears.
  - load coincident with wrap: the transfer uses pending contents from before this load; the new load is written to pending, pend_flag stays 1, and it is applied at the next wrap.
- NUM_DIGITS=1: idx is constant 0. Every terminal count is a wrap.
- Reset mid-frame: outputs go dark immediately (async). Pending data is lost.
- Elaboration check: illegal parameter values raise a $error.

Decomposition:
- Shared package svn_pkg:
  - SEG_OFF constant (7'b1111111)
  - glyph localparams for 0-F
  - segment-vector typedef, 7 bits, order CA..CG
- One sub-module svn_glyph_rom (combinational 4-bit code + HEX_EN -> 7-bit active-low glyph). It is instantiated once on the muxed digit.
- Scan counter, buffers and zero-suppress logic live in svn_scan_drv.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2, HEX_EN=1 unless stated.
1. Reset release, no load -> AN steps 1110,1101,1011,0111 every 8 cycles, each slot dark for its first 2 cycles. Segments 0000001 (digit "0"). frame_done pulses every 32 cycles.
2. load data_in=16'h1234, dp_in=4'b0100 mid-frame -> display unchanged until next wrap. Then digit0=4 (1001100), digit1=3, digit2=2 with DP=0, digit3=1.
3. data_in=16'h00A7, lz_en=1 -> digits 3 and 2 dark, digit1=A (0001000), digit0=7. Rerun with HEX_EN=0 -> digit1 dark.
4. data_in=16'h0000, lz_en=1 -> digits 3..1 dark, digit0 shows 0000001.
5. load 16'h1111 in the wrap cycle after an earlier pending load of 16'h2222 -> frame N shows 2222, frame N+1 shows 1111.
6. rst_n low for 1 cycle mid-slot -> AN=1111 and segments dark in the same cycle. After release, scan restarts at digit 0 with cnt=0 and shows 0000.

Source files
------------

// File: rtl/svn_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package svn_pkg;

  // Segment vector, bit 6 = CA down to bit 0 = CG, active-low.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  localparam seg_t GLYPH_0 = 7'b0000001;
  localparam seg_t GLYPH_1 = 7'b1001111;
  localparam seg_t GLYPH_2 = 7'b0010010;
  localparam seg_t GLYPH_3 = 7'b0000110;
  localparam seg_t GLYPH_4 = 7'b1001100;
  localparam seg_t GLYPH_5 = 7'b0100100;
  localparam seg_t GLYPH_6 = 7'b0100000;
  localparam seg_t GLYPH_7 = 7'b0001111;
  localparam seg_t GLYPH_8 = 7'b0000000;
  localparam seg_t GLYPH_9 = 7'b0000100;
  localparam seg_t GLYPH_A = 7'b0001000;
  localparam seg_t GLYPH_B = 7'b1100000;
  localparam seg_t GLYPH_C = 7'b0110001;
  localparam seg_t GLYPH_D = 7'b1000010;
  localparam seg_t GLYPH_E = 7'b0110000;
  localparam seg_t GLYPH_F = 7'b0111000;

endpackage

// File: rtl/svn_scan_drv_if.sv
// Load-side and display-side signal bundle of the scan driver.
// Latency: n/a (wiring only).
// Backpressure: none; load is a fire-and-forget strobe.
interface svn_scan_drv_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      lz_en;
  logic                      CA, CB, CC, CD, CE, CF, CG, DP;
  logic [NUM_DIGITS-1:0]     AN;
  logic                      frame_done;

  // Producer of display values, consumer of the pin outputs.
  modport master (
    output load, data_in, dp_in, lz_en,
    input  CA, CB, CC, CD, CE, CF, CG, DP, AN, frame_done
  );

  // The driver itself.
  modport slave (
    input  load, data_in, dp_in, lz_en,
    output CA, CB, CC, CD, CE, CF, CG, DP, AN, frame_done
  );
endinterface

// File: rtl/svn_glyph_rom.sv
// 4-bit digit code to active-low CA..CG glyph; hex letters optional.
// Latency: combinational.
// Backpressure: none.
module svn_glyph_rom
  import svn_pkg::*;
#(
  parameter int HEX_EN = 1
) (
  input  logic [3:0] code,
  output seg_t       seg
);

  // Table lookup; letters collapse to dark when hex display is disabled.
  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = (HEX_EN != 0) ? GLYPH_A : SEG_OFF;
      4'hB: seg = (HEX_EN != 0) ? GLYPH_B : SEG_OFF;
      4'hC: seg = (HEX_EN != 0) ? GLYPH_C : SEG_OFF;
      4'hD: seg = (HEX_EN != 0) ? GLYPH_D : SEG_OFF;
      4'hE: seg = (HEX_EN != 0) ? GLYPH_E : SEG_OFF;
      4'hF: seg = (HEX_EN != 0) ? GLYPH_F : SEG_OFF;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/svn_scan_drv.sv
// Multiplexed common-anode 7-segment driver with blanking gap, LZ suppress, frame-synchronous double buffer.
// Latency: pin outputs registered one cycle after scan state; loaded values appear at the next frame wrap.
// Backpressure: none; loads are always accepted, the last load before a wrap wins.
module svn_scan_drv
  import svn_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int HEX_EN      = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  svn_scan_drv_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Reject parameter combinations the scan logic is not built for.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("svn_scan_drv: NUM_DIGITS must be 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("svn_scan_drv: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYC < 0 || BLANK_CYC > REFRESH_DIV - 1) begin : g_bad_blank
    $error("svn_scan_drv: BLANK_CYC must be 0..REFRESH_DIV-1");
  end

  // Scan position.
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  // Pending (written by load) and active (displayed) buffers.
  logic [4*NUM_DIGITS-1:0] pend_dat_q, pend_dat_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_lz_q, pend_lz_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] act_dat_q, act_dat_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic                    act_lz_q, act_lz_d;

  // Registered pin state.
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tc, wrap, blank;
  logic [3:0]              dig_code;
  logic                    dig_dp, dig_supp;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_run;
  seg_t                    glyph;

  // Slot counter and digit index; wrap marks the frame boundary.
  always_comb begin
    tc    = (cnt_q == CNT_TC);
    wrap  = tc && (idx_q == IDX_LAST);
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tc) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    frame_done_d = wrap;
  end

  // Double buffer: a wrap transfers what was pending before any same-cycle load.
  always_comb begin
    pend_dat_d  = pend_dat_q;
    pend_dp_d   = pend_dp_q;
    pend_lz_d   = pend_lz_q;
    pend_flag_d = pend_flag_q;
    act_dat_d   = act_dat_q;
    act_dp_d    = act_dp_q;
    act_lz_d    = act_lz_q;
    if (wrap && pend_flag_q) begin
      act_dat_d   = pend_dat_q;
      act_dp_d    = pend_dp_q;
      act_lz_d    = pend_lz_q;
      pend_flag_d = 1'b0;
    end
    if (bus.load) begin
      pend_dat_d  = bus.data_in;
      pend_dp_d   = bus.dp_in;
      pend_lz_d   = bus.lz_en;
      pend_flag_d = 1'b1;
    end
  end

  // Leading-zero mask: blank from the top digit down while codes stay zero; digit 0 always shows.
  always_comb begin
    supp     = '0;
    zero_run = act_lz_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (act_dat_q[4*i +: 4] == 4'h0);
      supp[i]  = zero_run;
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    dig_code = 4'h0;
    dig_dp   = 1'b0;
    dig_supp = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        dig_code = act_dat_q[4*i +: 4];
        dig_dp   = act_dp_q[i];
        dig_supp = supp[i];
      end
    end
  end

  svn_glyph_rom #(
    .HEX_EN (HEX_EN)
  ) u_glyph_rom (
    .code (dig_code),
    .seg  (glyph)
  );

  // Next pin state: dark during the anti-ghost gap, otherwise one anode and its glyph.
  always_comb begin
    blank = (32'(cnt_q) < 32'(BLANK_CYC));
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = dig_supp ? SEG_OFF : glyph;
      dp_d  = ~dig_dp;
    end
  end

  // State and pin registers; reset forces the display dark and drops pending data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_dat_q   <= '0;
      pend_dp_q    <= '0;
      pend_lz_q    <= 1'b0;
      pend_flag_q  <= 1'b0;
      act_dat_q    <= '0;
      act_dp_q     <= '0;
      act_lz_q     <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_dat_q   <= pend_dat_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      pend_flag_q  <= pend_flag_d;
      act_dat_q    <= act_dat_d;
      act_dp_q     <= act_dp_d;
      act_lz_q     <= act_lz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign {bus.CA, bus.CB, bus.CC, bus.CD, bus.CE, bus.CF, bus.CG} = seg_q;
  assign bus.DP         = dp_q;
  assign bus.AN         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_svn_scan_drv.sv
// Directed bench for svn_scan_drv: a hex-enabled and a hex-disabled instance run in lockstep.
// Latency: each frame is 4 slots of 8 cycles, first 2 of every slot dark.
// Backpressure: none.
module tb_svn_scan_drv;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S3  = 7'b0000110;
  localparam logic [6:0] S4  = 7'b1001100;
  localparam logic [6:0] S7  = 7'b0001111;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0000100;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SB  = 7'b1100000;
  localparam logic [6:0] SC  = 7'b0110001;
  localparam logic [6:0] SD  = 7'b1000010;
  localparam logic [6:0] SE  = 7'b0110000;
  localparam logic [6:0] SF  = 7'b0111000;
  localparam logic [6:0] OFF = 7'b1111111;

  typedef struct {
    logic [15:0]     dat;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] eh;   // expected glyph per digit, hex instance
    logic [3:0][6:0] en;   // expected glyph per digit, non-hex instance
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  svn_scan_drv_if #(.NUM_DIGITS(ND)) bh ();
  svn_scan_drv_if #(.NUM_DIGITS(ND)) bn ();

  svn_scan_drv #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC), .HEX_EN(1)) u_hex (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bh)
  );

  svn_scan_drv #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC), .HEX_EN(0)) u_nohex (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bn)
  );

  logic [6:0] seg_h, seg_n;
  assign seg_h = {bh.CA, bh.CB, bh.CC, bh.CD, bh.CE, bh.CF, bh.CG};
  assign seg_n = {bn.CA, bn.CB, bn.CC, bn.CD, bn.CE, bn.CF, bn.CG};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] d, input logic [3:0] dp, input logic lz);
    bh.load = ld;  bh.data_in = d;  bh.dp_in = dp;  bh.lz_en = lz;
    bn.load = ld;  bn.data_in = d;  bn.dp_in = dp;  bn.lz_en = lz;
  endtask

  // One-cycle load strobe, captured at the next rising edge.
  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
    drive(1'b1, d, dp, lz);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  // Step until frame_done is seen, at most 200 cycles; returns cycles taken.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bh.frame_done && n < 200);
    chk("frame_done_seen", {31'b0, bh.frame_done}, 32'd1);
  endtask

  // Entered at a frame_done sample point; walks one full frame and ends at the next one.
  task automatic check_frame(input logic [3:0][6:0] eh, input logic [3:0][6:0] en,
                             input logic [3:0] edp, input string tag);
    logic [3:0] an_exp;
    for (int d = 0; d < 4; d++) begin
      step();
      chk($sformatf("%s_blank%0d_hex", tag, d), {19'b0, bh.AN, seg_h, bh.DP, bh.frame_done},
          {19'b0, 4'hF, OFF, 1'b1, 1'b0});
      chk($sformatf("%s_blank%0d_nohex", tag, d), {19'b0, bn.AN, seg_n, bn.DP, bn.frame_done},
          {19'b0, 4'hF, OFF, 1'b1, 1'b0});
      repeat (4) step();
      an_exp = ~(4'b0001 << d);
      chk($sformatf("%s_dig%0d_hex", tag, d), {20'b0, bh.AN, seg_h, bh.DP},
          {20'b0, an_exp, eh[d], ~edp[d]});
      chk($sformatf("%s_dig%0d_nohex", tag, d), {20'b0, bn.AN, seg_n, bn.DP},
          {20'b0, an_exp, en[d], ~edp[d]});
      repeat (3) step();
    end
    chk($sformatf("%s_fd_hex", tag), {31'b0, bh.frame_done}, 32'd1);
    chk($sformatf("%s_fd_nohex", tag), {31'b0, bn.frame_done}, 32'd1);
  endtask

  vec_t       tv [6];
  int         n;
  logic [6:0] prev_h, prev_n;
  logic       prev_dp;

  initial begin
    tv[0] = '{dat: 16'h1234, dp: 4'b0100, lz: 1'b0, eh: {S1, S2, S3, S4},     en: {S1, S2, S3, S4}};
    tv[1] = '{dat: 16'h00A7, dp: 4'b0000, lz: 1'b1, eh: {OFF, OFF, SA, S7},   en: {OFF, OFF, OFF, S7}};
    tv[2] = '{dat: 16'h0000, dp: 4'b0000, lz: 1'b1, eh: {OFF, OFF, OFF, S0},  en: {OFF, OFF, OFF, S0}};
    tv[3] = '{dat: 16'h0809, dp: 4'b1001, lz: 1'b1, eh: {OFF, S8, S0, S9},    en: {OFF, S8, S0, S9}};
    tv[4] = '{dat: 16'hBCDE, dp: 4'b0000, lz: 1'b1, eh: {SB, SC, SD, SE},     en: {OFF, OFF, OFF, OFF}};
    tv[5] = '{dat: 16'hF000, dp: 4'b0010, lz: 1'b1, eh: {SF, S0, S0, S0},     en: {OFF, S0, S0, S0}};

    drive(1'b0, 16'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_state_hex", {19'b0, bh.AN, seg_h, bh.DP, bh.frame_done}, {19'b0, 4'hF, OFF, 1'b1, 1'b0});
    chk("reset_state_nohex", {19'b0, bn.AN, seg_n, bn.DP, bn.frame_done}, {19'b0, 4'hF, OFF, 1'b1, 1'b0});
    rst_n = 1'b1;

    // Scan from reset: first wrap after exactly one frame, then a frame of zeros.
    wait_frame(n);
    chk("first_frame_len", n, 32'd32);
    check_frame({S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b0000, "idle");

    // Table: load just after a frame boundary; old value holds until the next wrap.
    prev_h  = S0;
    prev_n  = S0;
    prev_dp = 1'b0;
    for (int v = 0; v < 6; v++) begin
      do_load(tv[v].dat, tv[v].dp, tv[v].lz);
      repeat (3) step();
      chk($sformatf("v%0d_hold_hex", v), {20'b0, bh.AN, seg_h, bh.DP}, {20'b0, 4'b1110, prev_h, ~prev_dp});
      chk($sformatf("v%0d_hold_nohex", v), {20'b0, bn.AN, seg_n, bn.DP}, {20'b0, 4'b1110, prev_n, ~prev_dp});
      wait_frame(n);
      chk($sformatf("v%0d_wrap_dist", v), n, 32'd28);
      check_frame(tv[v].eh, tv[v].en, tv[v].dp, $sformatf("v%0d", v));
      prev_h  = tv[v].eh[0];
      prev_n  = tv[v].en[0];
      prev_dp = tv[v].dp[0];
    end

    // Load coincident with wrap: older pending value shows first, newer one a frame later.
    do_load(16'h2222, 4'b0000, 1'b0);
    repeat (30) step();
    drive(1'b1, 16'h1111, 4'b0000, 1'b0);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("coinc_wrap_fd", {31'b0, bh.frame_done}, 32'd1);
    check_frame({S2, S2, S2, S2}, {S2, S2, S2, S2}, 4'b0000, "coinc_n");
    check_frame({S1, S1, S1, S1}, {S1, S1, S1, S1}, 4'b0000, "coinc_n1");

    // Mid-slot reset: dark at once, pending data discarded, scan restarts from digit 0.
    do_load(16'h5555, 4'b1111, 1'b0);
    repeat (3) step();
    chk("pre_rst_lit", {20'b0, bh.AN, seg_h, bh.DP}, {20'b0, 4'b1110, S1, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("rst_async_hex", {19'b0, bh.AN, seg_h, bh.DP, bh.frame_done}, {19'b0, 4'hF, OFF, 1'b1, 1'b0});
    chk("rst_async_nohex", {19'b0, bn.AN, seg_n, bn.DP, bn.frame_done}, {19'b0, 4'hF, OFF, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_frame(n);
    chk("post_rst_frame_len", n, 32'd32);
    check_frame({S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b0000, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
